// File: rtl/dp_test_pkg.sv
// rtl/dp_test_pkg.sv - shared FSM encoding and AXI response codes for dp_test_lm
//
// Purpose : State encoding of the local-to-AXI bridge FSM, the AXI response
//           constants and a helper that classifies a response as an error.
// Ports   : none (package)
package dp_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RRESP = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Any non-OKAY code (EXOKAY included) is reported as an error to the local side.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/dp_test_lm.sv
// rtl/dp_test_lm.sv - single-outstanding local request to AXI4-Lite master bridge
//
// Purpose : Turns a level-held local request (LOCAL_CS/RNW/ADDR/BE/WDATA) into
//           one AXI write (AW+W then B) or read (AR then R) and acknowledges it
//           with LOCAL_ACK until the requester drops LOCAL_CS.
// Ports   : ACLK, ARESETN (async, active-low)
//           LOCAL_CS/RNW/ADDR/BE/WDATA in; LOCAL_ACK/RDATA/ERR out
//           M_AXI_AW*, M_AXI_W*, M_AXI_B*, M_AXI_AR*, M_AXI_R* master channels
module dp_test_lm
    import dp_test_pkg::*;
#(
    parameter logic [3:0] AXI_CACHE = 4'b0011,
    parameter logic [2:0] AXI_PROT  = 3'b000
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        LOCAL_CS,
    input  logic        LOCAL_RNW,
    input  logic [31:0] LOCAL_ADDR,
    input  logic [3:0]  LOCAL_BE,
    input  logic [31:0] LOCAL_WDATA,
    output logic        LOCAL_ACK,
    output logic [31:0] LOCAL_RDATA,
    output logic        LOCAL_ERR,
    output logic [15:0] M_AXI_AWADDR,
    output logic [3:0]  M_AXI_AWCACHE,
    output logic [2:0]  M_AXI_AWPROT,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    input  logic [1:0]  M_AXI_BRESP,
    output logic [15:0] M_AXI_ARADDR,
    output logic [3:0]  M_AXI_ARCACHE,
    output logic [2:0]  M_AXI_ARPROT,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic        err_q, err_d;

    // Only the low 16 address bits reach the AXI side.
    logic unused_addr_hi;
    assign unused_addr_hi = ^LOCAL_ADDR[31:16];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        err_d     = err_q;

        // Each VALID retires on its own handshake; AW and W may finish in any order.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (arvalid_q && M_AXI_ARREADY) arvalid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (LOCAL_CS) begin
                    addr_d    = LOCAL_ADDR[15:0];
                    be_d      = LOCAL_BE;
                    wdata_d   = LOCAL_WDATA;
                    awvalid_d = !LOCAL_RNW;
                    wvalid_d  = !LOCAL_RNW;
                    arvalid_d = LOCAL_RNW;
                    state_d   = LOCAL_RNW ? ST_RADDR : ST_WADDR;
                end
            end
            ST_WADDR: begin
                // A channel counts as done if it already handshook or does so now.
                if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY))
                    state_d = ST_WRESP;
            end
            ST_WRESP: begin
                if (M_AXI_BVALID) begin
                    err_d   = resp_is_err(M_AXI_BRESP);
                    state_d = ST_DONE;
                end
            end
            ST_RADDR: begin
                if (M_AXI_ARREADY) state_d = ST_RRESP;
            end
            ST_RRESP: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    err_d   = resp_is_err(M_AXI_RRESP);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Stay here while CS is still held so the request is not re-issued.
                if (!LOCAL_CS) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign LOCAL_ACK     = (state_q == ST_DONE);
    assign LOCAL_RDATA   = rdata_q;
    assign LOCAL_ERR     = err_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWCACHE = AXI_CACHE;
    assign M_AXI_AWPROT  = AXI_PROT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = be_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == ST_WRESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARCACHE = AXI_CACHE;
    assign M_AXI_ARPROT  = AXI_PROT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = (state_q == ST_RRESP);

endmodule
